param_program_sequencer: RTL and testbench
==========================================

PARAM_PROGRAM_SEQUENCER -- requirements
Module: param_program_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 8: program-memory address width.
- JUMP_W, 4: jump_addr width; the target is {jump_addr, (ADDR_W-JUMP_W) zeros}.
- PHASES, 4: clock phases per instruction, at least 2.
- RUN_PHASE, 2: phase in which run pulses, in the range 1..PHASES-1.
- STACK_DEPTH, 4: return-stack entries, at least 1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- sync_reset, in, 1: synchronous restart, active high.
- hold, in, 1: freezes sequencing.
- jump, in, 1: unconditional jump.
- conditional_jump, in, 1: conditional jump.
- dont_jump_flag, in, 1: suppresses conditional_jump.
- call, in, 1: push the return address, then jump.
- ret, in, 1: pop the return address into the PC.
- jump_addr, in, JUMP_W: jump or call target, upper bits.
- pm_address, out, ADDR_W: program-memory address (combinational).
- pc, out, ADDR_W: registered program counter.
- phase, out, max(1,$clog2(PHASES)): current instruction phase.
- run, out, 1: execute strobe.
- from_PS, out, ADDR_W: current top-of-stack value (0 when the stack is empty).
- stack_overflow, out, 1: sticky error flag.
- stack_underflow, out, 1: sticky error flag.

Function
REQ-003 phase SHALL count 0..PHASES-1 and wrap to 0; it holds its value while hold=1.
REQ-004 pc SHALL load pm_address on every rising edge of clk.
REQ-005 pm_address SHALL equal pc, except at phase==PHASES-1 with hold=0, where it equals the next address per REQ-006.
REQ-006 The next address SHALL be selected with this priority:
- ret, if the stack is not empty: the popped top of stack.
- call, if the stack is not full: the jump target, with pc+1 pushed.
- jump: the jump target.
- conditional_jump with dont_jump_flag=0: the jump target.
- otherwise: pc+1.
REQ-007 pc+1 SHALL wrap modulo 2^ADDR_W (for example 0xFF -> 0x00 at ADDR_W=8).
REQ-008 ret on an empty stack SHALL yield pc+1 with the stack unchanged, and SHALL set stack_underflow.
REQ-009 call on a full stack SHALL yield pc+1 with no push and no jump, and SHALL set stack_overflow.
REQ-010 call and ret asserted together SHALL behave as ret alone.
REQ-011 Control inputs sampled outside phase PHASES-1, or while hold=1, SHALL have no effect.
REQ-012 run SHALL be 1 exactly when phase==RUN_PHASE and hold=0, giving one pulse per instruction.
REQ-013 Push and pop SHALL take effect on the same edge at which pc loads the new address.
REQ-014 stack_overflow and stack_underflow SHALL stay set until a reset.

Reset
REQ-015 reset_n=0 SHALL immediately clear, without waiting for clk, all of the following:
- pc=0, phase=0, stack pointer=0, both error flags=0;
- pm_address=0, run=0, from_PS=0.
REQ-016 sync_reset=1 SHALL force pm_address=0 combinationally, and SHALL produce the REQ-015 state at the next edge, regardless of hold or phase.
REQ-017 A reset asserted mid-instruction SHALL abandon that instruction; sequencing restarts at address 0, phase 0.
REQ-018 Stack contents SHALL need no reset; only the pointer defines validity.

Structure
REQ-019 Package param_program_sequencer_pkg SHALL hold:
- an enum for the next-address source (NPC_RESET, NPC_RET, NPC_CALL, NPC_JUMP, NPC_INC);
- the default parameter constants.
REQ-020 The return stack SHALL be a sub-module, ps_return_stack, with these properties:
- parameters for width and depth;
- push and pop inputs;
- full, empty and top outputs;
- the same clock and reset as the parent.

Verification
All scenarios use the default parameters.
REQ-021 Free run after reset release: pc steps 0x00 -> 0x01 once every 4 clocks, and run pulses once per instruction, at phase 2.
REQ-022 jump=1 with jump_addr=0xA, held through phase 3: pc=0xA0 after that edge. With conditional_jump=1: dont_jump_flag=1 gives pc+1, and dont_jump_flag=0 gives 0xA0.
REQ-023 call with jump_addr=0x3 at pc=0x05: pc=0x30 and from_PS=0x06. A later ret: pc=0x06 and from_PS=0x00.
REQ-024 Five nested calls: the fifth is ignored (pc+1) and stack_overflow=1. Five returns then follow: the fifth yields pc+1 and stack_underflow=1.
REQ-025 Wrap and hold:
- at pc=0xFF, the next instruction gives pc=0x00;
- hold=1 for 3 clocks at phase 3 keeps phase at 3, pc unchanged and run=0, and sequencing resumes on release;
- reset_n low at phase 1 immediately gives pc=0 and phase=0.

Source files
------------

// File: rtl/param_program_sequencer_pkg.sv
// param_program_sequencer_pkg: shared defaults and next-address source encoding
package param_program_sequencer_pkg;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_JUMP_W      = 4;
  localparam int DEF_PHASES      = 4;
  localparam int DEF_RUN_PHASE   = 2;
  localparam int DEF_STACK_DEPTH = 4;
  typedef enum logic [2:0] {NPC_RESET, NPC_RET, NPC_CALL, NPC_JUMP, NPC_INC} npc_src_e;
endpackage

// File: rtl/ps_return_stack.sv
// ps_return_stack: LIFO of return addresses
//   clk/reset_n : clock and async active-low reset (pointer only)
//   clr         : synchronous pointer clear
//   push/pop    : ignored when full/empty respectively
//   din         : value pushed
//   full/empty  : occupancy flags
//   top         : top-of-stack value, 0 when empty
module ps_return_stack
  import param_program_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W,
  parameter int DEPTH = DEF_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  assign empty = ptr_q == '0;
  assign full  = ptr_q == PW'(DEPTH);
  assign top   = empty ? '0 : mem_q[AW'(ptr_q - PW'(1))];
  always_comb
    ptr_d = clr            ? '0 :
            push && !full  ? ptr_q + PW'(1) :
            pop  && !empty ? ptr_q - PW'(1) : ptr_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  // Contents need no reset: the pointer alone defines which entries are valid.
  always_ff @(posedge clk)
    if (push && !full && !clr) mem_q[AW'(ptr_q)] <= din;
endmodule

// File: rtl/param_program_sequencer.sv
// param_program_sequencer: phased program counter with jump/call/return and return stack
//   clk, reset_n (async active-low), sync_reset (sync restart)
//   hold                      : freezes phase and sequencing
//   jump, conditional_jump, dont_jump_flag, call, ret, jump_addr : control, sampled in last phase
//   pm_address                : combinational next program-memory address
//   pc, phase, run            : registered PC, instruction phase, execute strobe
//   from_PS                   : top of return stack (0 if empty)
//   stack_overflow/underflow  : sticky error flags
module param_program_sequencer
  import param_program_sequencer_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int JUMP_W      = DEF_JUMP_W,
  parameter int PHASES      = DEF_PHASES,
  parameter int RUN_PHASE   = DEF_RUN_PHASE,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         sync_reset,
  input  logic                                         hold,
  input  logic                                         jump,
  input  logic                                         conditional_jump,
  input  logic                                         dont_jump_flag,
  input  logic                                         call,
  input  logic                                         ret,
  input  logic [JUMP_W-1:0]                            jump_addr,
  output logic [ADDR_W-1:0]                            pm_address,
  output logic [ADDR_W-1:0]                            pc,
  output logic [(PHASES > 1 ? $clog2(PHASES) : 1)-1:0] phase,
  output logic                                         run,
  output logic [ADDR_W-1:0]                            from_PS,
  output logic                                         stack_overflow,
  output logic                                         stack_underflow
);
  localparam int PH_W = PHASES > 1 ? $clog2(PHASES) : 1;
  logic [ADDR_W-1:0] pc_q, pc_inc, target, npc, top;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              last, adv, push, pop, full, empty;
  npc_src_e          src;
  always_comb begin
    last    = phase_q == PH_W'(PHASES - 1);
    adv     = last && !hold && !sync_reset;
    pc_inc  = pc_q + ADDR_W'(1);
    target  = ADDR_W'(jump_addr) << (ADDR_W - JUMP_W);
    // ret outranks call, so call+ret together behaves as ret alone
    src     = sync_reset ? NPC_RESET :
              ret        ? (empty ? NPC_INC : NPC_RET) :
              call       ? (full  ? NPC_INC : NPC_CALL) :
              (jump || (conditional_jump && !dont_jump_flag)) ? NPC_JUMP : NPC_INC;
    npc     = src == NPC_RESET ? '0 :
              src == NPC_RET   ? top :
              (src == NPC_CALL || src == NPC_JUMP) ? target : pc_inc;
    pm_address = sync_reset ? '0 : adv ? npc : pc_q;
    push    = adv && src == NPC_CALL;
    pop     = adv && src == NPC_RET;
    ovf_d   = !sync_reset && (ovf_q || (adv && !ret && call && full));
    unf_d   = !sync_reset && (unf_q || (adv && ret && empty));
    phase_d = sync_reset ? '0 : hold ? phase_q : last ? '0 : phase_q + PH_W'(1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc_q    <= '0;
      phase_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pm_address;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  ps_return_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (sync_reset),
    .push   (push),
    .pop    (pop),
    .din    (pc_inc),
    .full   (full),
    .empty  (empty),
    .top    (top)
  );
  assign pc              = pc_q;
  assign phase           = phase_q;
  assign run             = !hold && phase_q == PH_W'(RUN_PHASE);
  assign from_PS         = top;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
endmodule

// File: tb/tb_param_program_sequencer.sv
// tb_param_program_sequencer: scoreboard bench with instruction-level reference model
module tb_param_program_sequencer;
  logic       clk = 0, reset_n = 0, sync_reset = 0, hold = 0;
  logic       jump = 0, conditional_jump = 0, dont_jump_flag = 0, call = 0, ret = 0;
  logic [3:0] jump_addr = 0;
  logic [7:0] pm_address, pc, from_PS;
  logic [1:0] phase;
  logic       run, stack_overflow, stack_underflow;

  param_program_sequencer dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .hold(hold),
    .jump(jump), .conditional_jump(conditional_jump), .dont_jump_flag(dont_jump_flag),
    .call(call), .ret(ret), .jump_addr(jump_addr),
    .pm_address(pm_address), .pc(pc), .phase(phase), .run(run), .from_PS(from_PS),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] pc; logic [7:0] fps; logic ovf; logic unf;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  int         n_vec = 0, n_err = 0;
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t m_state();
    return {m_pc, (m_stk.size() > 0) ? m_stk[$] : 8'h00, m_ovf, m_unf};
  endfunction

  function automatic void m_reset();
    m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    sb.delete();
    sb.push_back(m_state());
  endfunction

  // One instruction boundary, straight from the sequencing rules.
  function automatic void m_step(input logic j, cj, dj, c, r, input logic [3:0] ja);
    logic [7:0] t = {ja, 4'h0};
    if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = m_pc + 8'd1; m_unf = 1; end
    end else if (c) begin
      if (m_stk.size() < 4) begin m_stk.push_back(m_pc + 8'd1); m_pc = t; end
      else begin m_pc = m_pc + 8'd1; m_ovf = 1; end
    end else if (j || (cj && !dj)) m_pc = t;
    else m_pc = m_pc + 8'd1;
    sb.push_back(m_state());
  endfunction

  // Monitor: every run strobe presents one instruction's state.
  always @(negedge clk)
    if (reset_n && run) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL run_unexpected: got run with pc %0h, expected no run", pc);
      end else begin
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("from_PS", from_PS, e.fps);
        check("stack_overflow", stack_overflow, e.ovf);
        check("stack_underflow", stack_underflow, e.unf);
        check("run_phase", phase, 2);
      end
    end

  task automatic junk();
    {jump, conditional_jump, dont_jump_flag, call, ret} = 5'($urandom);
    jump_addr = 4'($urandom);
  endtask

  // Called at the negedge where phase==0; returns at the next phase-0 negedge.
  task automatic instr(input logic j = 0, cj = 0, dj = 0, c = 0, r = 0,
                       input logic [3:0] ja = 0, input int hc = 0);
    repeat (3) begin junk(); @(negedge clk); end
    if (hc > 0) begin
      hold = 1;
      repeat (hc) begin junk(); @(negedge clk); end
      check("hold_phase", phase, 3);
      check("hold_run", run, 0);
      check("hold_pc", pc, m_pc);
      check("hold_pm_address", pm_address, m_pc);
      hold = 0;
    end
    {jump, conditional_jump, dont_jump_flag, call, ret} = {j, cj, dj, c, r};
    jump_addr = ja;
    @(negedge clk);
    {jump, conditional_jump, dont_jump_flag, call, ret} = 0;
    jump_addr = 0;
    m_step(j, cj, dj, c, r, ja);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_phase", phase, 0);
    check("rst_run", run, 0);
    check("rst_pm_address", pm_address, 0);
    check("rst_from_PS", from_PS, 0);
    check("rst_ovf", stack_overflow, 0);
    check("rst_unf", stack_underflow, 0);
    reset_n = 1;
    m_reset();
    instr(); instr();
    instr(.j(1), .ja(4'hA));
    instr(.cj(1), .dj(1), .ja(4'hA));
    instr(.cj(1), .ja(4'hA));
    instr(.j(1), .ja(4'h0));
    repeat (5) instr();
    instr(.c(1), .ja(4'h3));
    instr(.r(1));
    for (int i = 1; i <= 5; i++) instr(.c(1), .ja(4'(i)));
    repeat (5) instr(.r(1));
    instr(.c(1), .r(1), .ja(4'h7));
    instr(.c(1), .ja(4'h2));
    instr(.c(1), .r(1), .ja(4'h7));
    instr(.j(1), .ja(4'hF));
    repeat (16) instr();
    instr(.hc(3));
    instr(.c(1), .ja(4'h5));
    // asynchronous reset in phase 1
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_phase", phase, 0);
    check("arst_pm_address", pm_address, 0);
    check("arst_from_PS", from_PS, 0);
    check("arst_run", run, 0);
    check("arst_ovf", stack_overflow, 0);
    check("arst_unf", stack_underflow, 0);
    @(negedge clk);
    reset_n = 1;
    m_reset();
    instr(); instr(.c(1), .ja(4'h9)); instr(.r(1)); instr(.r(1));
    // synchronous reset in phase 1, with hold asserted
    @(negedge clk);
    sync_reset = 1; hold = 1;
    #1 check("srst_pm_address", pm_address, 0);
    @(negedge clk);
    check("srst_pc", pc, 0);
    check("srst_phase", phase, 0);
    check("srst_unf", stack_underflow, 0);
    check("srst_from_PS", from_PS, 0);
    sync_reset = 0; hold = 0;
    m_reset();
    for (int i = 0; i < 150; i++)
      instr(.j($urandom_range(0, 3) == 0), .cj($urandom_range(0, 2) == 0),
            .dj($urandom_range(0, 1) == 0), .c($urandom_range(0, 3) == 0),
            .r($urandom_range(0, 3) == 0), .ja(4'($urandom)),
            .hc($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0));
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
